// File: rtl/port_uart_pkg.sv
// Shared types and constants for the output-port UART transmitter.
package port_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 8;

endpackage

// File: rtl/port_fifo.sv
// Synchronous FIFO with true occupancy count and a sticky overflow flag.
// A write while full is still accepted if a pop happens on the same edge.
module port_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int LVL_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level,
    output logic             overflow
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             ovf_q, ovf_d;
    logic             push;

    assign full     = (level_q == LVL_W'(DEPTH));
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign overflow = ovf_q;
    assign rd_data  = mem_q[rd_ptr_q];

    // Next pointers, occupancy and overflow; pop frees the slot the write needs.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        push     = wr_en && (!full || rd_en);
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, rd_en})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (wr_en && full && !rd_en) begin
            ovf_d = 1'b1;
        end
    end

    // Pointer, level and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage array; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/port_uart_tx.sv
// Buffers bytes written to the CPU output port and sends them as 8N1 UART.
// tx is registered from the current state, so it lags the state by one cycle.
module port_uart_tx
    import port_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8,
    parameter int LVL_W        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       portData,
    input  logic             portWen,
    input  logic             ovfClr,
    output logic             tx,
    output logic             busy,
    output logic             empty,
    output logic             full,
    output logic [LVL_W-1:0] level,
    output logic             overflow
);

    localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [2:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 tx_q, tx_d;
    logic                 pop;
    logic                 baud_tick;
    logic [7:0]           fifo_head;

    port_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (portWen),
        .wr_data  (portData),
        .rd_en    (pop),
        .ovf_clr  (ovfClr),
        .rd_data  (fifo_head),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow)
    );

    assign tx        = tx_q;
    assign busy      = (state_q != IDLE);
    assign baud_tick = (baud_q == BAUD_LAST);

    // Frame sequencing: pop, start bit, eight data bits LSB first, stop bit.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        pop     = 1'b0;
        tx_d    = 1'b1;
        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shreg_d = fifo_head;
                    state_d = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (baud_tick) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                tx_d = shreg_q[0];
                if (baud_tick) begin
                    baud_d  = '0;
                    shreg_d = {1'b0, shreg_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BIT_LAST) begin
                        state_d = STOP;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (baud_tick) begin
                    baud_d = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        shreg_d = fifo_head;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters, shifter and the registered line driver.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: tb/tb_port_uart_tx.sv
// Self-checking bench for port_uart_tx: vector table, frame timing checks and
// a UART receiver feeding a byte scoreboard.
module tb_port_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int LW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    portData = 8'h00;
    logic          portWen = 1'b0;
    logic          ovfClr = 1'b0;
    logic          tx, busy, empty, full, overflow;
    logic [LW-1:0] level;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rx_frames = 0;
    logic [7:0] exp_q[$];
    int starts_q[$];

    typedef struct {
        logic       wen;
        logic [7:0] d;
        logic       ovc;
        logic       etx;
        logic       ebusy;
        logic       eempty;
        logic       efull;
        int         elvl;
        logic       eovf;
    } vec_t;

    vec_t vt[8];

    port_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .LVL_W        (LW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .portData (portData),
        .portWen  (portWen),
        .ovfClr   (ovfClr),
        .tx       (tx),
        .busy     (busy),
        .empty    (empty),
        .full     (full),
        .level    (level),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d);
        portData = d;
        portWen  = 1'b1;
        step();
        portWen  = 1'b0;
    endtask

    task automatic chk_all(input string nm, input logic etx, input logic ebusy, input logic eempty,
                           input logic efull, input int elvl, input logic eovf);
        chk({nm, "_tx"}, int'(tx), int'(etx));
        chk({nm, "_busy"}, int'(busy), int'(ebusy));
        chk({nm, "_empty"}, int'(empty), int'(eempty));
        chk({nm, "_full"}, int'(full), int'(efull));
        chk({nm, "_level"}, int'(level), elvl);
        chk({nm, "_ovf"}, int'(overflow), int'(eovf));
    endtask

    // UART receiver: samples mid-bit, aborts a frame cut by reset, scores bytes.
    initial begin : monitor
        logic [7:0] b;
        logic       ab;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && tx === 1'b0) begin
                starts_q.push_back(cyc);
                ab = 1'b0;
                b  = 8'h00;
                for (int c = 1; c < 10 * CPB; c++) begin
                    @(negedge clk);
                    if (rst !== 1'b0) ab = 1'b1;
                    if (c >= CPB && c < 9 * CPB && (c % CPB) == CPB / 2) b[(c / CPB) - 1] = tx;
                    if (c == 9 * CPB + CPB / 2 && !ab) chk("stop_bit", int'(tx), 1);
                end
                if (!ab) begin
                    rx_frames++;
                    if (exp_q.size() == 0) chk("rx_unexpected_byte", int'(b), -1);
                    else chk("rx_byte", int'(b), int'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin : stim
        int w0, k, txerr, berr, t, lows, rx0;
        logic etx;
        logic [7:0] bv;

        // idle, write 0xA5, then the first edges of its frame
        vt[0] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0};
        vt[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0};
        vt[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0};
        vt[3] = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0};
        vt[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0};
        vt[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0};
        vt[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0};
        vt[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0};

        // reset and idle
        rst = 1'b1;
        step();
        step();
        chk_all("in_reset", 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk_all("idle", 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        end

        // single byte: vector table then cycle-accurate frame shape
        w0 = 0;
        starts_q.delete();
        for (int i = 0; i < 8; i++) begin
            portData = vt[i].d;
            portWen  = vt[i].wen;
            ovfClr   = vt[i].ovc;
            if (vt[i].wen) exp_q.push_back(vt[i].d);
            step();
            if (vt[i].wen) w0 = cyc;
            portWen = 1'b0;
            ovfClr  = 1'b0;
            chk_all($sformatf("vec%0d", i), vt[i].etx, vt[i].ebusy, vt[i].eempty,
                    vt[i].efull, vt[i].elvl, vt[i].eovf);
        end
        bv = 8'hA5;
        txerr = 0;
        berr = 0;
        for (int e = w0 + 5; e <= w0 + 44; e++) begin
            step();
            k = e - w0 - 2;
            if (k < CPB) etx = 1'b0;
            else if (k < 9 * CPB) etx = bv[(k - CPB) / CPB];
            else etx = 1'b1;
            if (tx !== etx) txerr++;
            if (busy !== (e < w0 + 41)) berr++;
        end
        chk("a5_tx_shape_errs", txerr, 0);
        chk("a5_busy_errs", berr, 0);
        chk("a5_starts", starts_q.size(), 1);
        if (starts_q.size() >= 1) chk("a5_start_edge", starts_q[0], w0 + 2);
        chk("a5_sb_left", exp_q.size(), 0);

        // three back-to-back frames
        starts_q.delete();
        wr(8'h01);
        w0 = cyc;
        wr(8'h02);
        chk("b2b_busy_e1", int'(busy), 1);
        wr(8'h03);
        chk("b2b_level_e2", int'(level), 2);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h03);
        t = 0;
        while (busy === 1'b1 && t < 400) begin
            step();
            t++;
        end
        chk("b2b_busy_fall_edge", cyc, w0 + 121);
        step();
        step();
        chk("b2b_starts", starts_q.size(), 3);
        if (starts_q.size() == 3) begin
            chk("b2b_start0", starts_q[0], w0 + 2);
            chk("b2b_start1", starts_q[1], w0 + 42);
            chk("b2b_start2", starts_q[2], w0 + 82);
        end
        chk("b2b_sb_left", exp_q.size(), 0);

        // overflow, clear, then write while full on the STOP-end pop edge
        rx0 = rx_frames;
        w0 = 0;
        for (int i = 0; i < 10; i++) begin
            wr(8'h10 + 8'(i));
            if (i == 0) w0 = cyc;
            if (i <= 8) exp_q.push_back(8'h10 + 8'(i));
            if (i == 8) begin
                chk("ovf_full_at8", int'(full), 1);
                chk("ovf_level_at8", int'(level), 8);
                chk("ovf_flag_at8", int'(overflow), 0);
            end
        end
        chk("ovf_flag_set", int'(overflow), 1);
        chk("ovf_level_after_drop", int'(level), 8);
        ovfClr = 1'b1;
        step();
        ovfClr = 1'b0;
        chk("ovf_cleared", int'(overflow), 0);
        while (cyc < w0 + 40) step();
        chk("wfp_full_before", int'(full), 1);
        portData = 8'h77;
        portWen  = 1'b1;
        step();
        portWen  = 1'b0;
        exp_q.push_back(8'h77);
        chk("wfp_edge", cyc, w0 + 41);
        chk("wfp_level", int'(level), 8);
        chk("wfp_full", int'(full), 1);
        chk("wfp_ovf", int'(overflow), 0);
        t = 0;
        while ((busy !== 1'b0 || empty !== 1'b1) && t < 600) begin
            step();
            t++;
        end
        chk("drain_timeout", int'(t < 600), 1);
        step();
        step();
        chk("drain_frames", rx_frames - rx0, 10);
        chk("drain_sb_left", exp_q.size(), 0);

        // reset mid-DATA with bytes queued
        rx0 = rx_frames;
        wr(8'h5A);
        w0 = cyc;
        wr(8'hB1);
        wr(8'hB2);
        wr(8'hB3);
        chk("rst_q_level", int'(level), 3);
        while (cyc < w0 + 20) step();
        chk("rst_mid_busy", int'(busy), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_all("after_rst", 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (tx !== 1'b1 || busy !== 1'b0) lows++;
        end
        chk("post_rst_quiet", lows, 0);
        chk("post_rst_frames", rx_frames - rx0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
